// File: rtl/vga_ctrl.sv
// rtl/vga_ctrl.sv - 640x480@60 VGA timing controller with one-cycle-early pixel request
//
// Purpose:
//   Runs the horizontal/vertical pixel counters and decodes sync, pixel
//   request coordinates, gated RGB and a frame-start pulse from them.
//
// Ports:
//   vga_clk     in   1   pixel clock
//   sys_rst     in   1   asynchronous active-high reset
//   pix_data    in  16   RGB565 pixel from generator (registered there, 1-cycle latency)
//   pix_x       out 10   requested column, 10'h3FF outside the request window
//   pix_y       out 10   requested row, 10'h3FF outside the request window
//   hsync       out  1   horizontal sync, active-low
//   vsync       out  1   vertical sync, active-low
//   rgb         out 16   pixel to DAC, zero outside the active window
//   frame_start out  1   high while both counters are at zero
module vga_ctrl #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 40,
  parameter int H_LEFT   = 8,
  parameter int H_VALID  = 640,
  parameter int H_RIGHT  = 8,
  parameter int H_FRONT  = 8,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 25,
  parameter int V_TOP    = 8,
  parameter int V_VALID  = 480,
  parameter int V_BOTTOM = 8,
  parameter int V_FRONT  = 2
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] rgb,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;
  localparam int H_ACT   = H_SYNC + H_BACK + H_LEFT;
  localparam int V_ACT   = V_SYNC + V_BACK + V_TOP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_BEG  = 10'(H_ACT);
  localparam logic [9:0] H_ACT_END  = 10'(H_ACT + H_VALID);
  // Request window leads the display window by one clock to cover the
  // generator's output register.
  localparam logic [9:0] H_REQ_BEG  = 10'(H_ACT - 1);
  localparam logic [9:0] H_REQ_END  = 10'(H_ACT + H_VALID - 1);
  localparam logic [9:0] V_ACT_BEG  = 10'(V_ACT);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACT + V_VALID);

  logic [9:0] cnt_h_q, cnt_h_d;
  logic [9:0] cnt_v_q, cnt_v_d;

  logic v_in_window;
  logic rgb_valid;
  logic pix_data_req;

  always_comb begin
    cnt_h_d = cnt_h_q + 10'd1;
    cnt_v_d = cnt_v_q;
    if (cnt_h_q == H_LAST) begin
      cnt_h_d = 10'd0;
      if (cnt_v_q == V_LAST) begin
        cnt_v_d = 10'd0;
      end else begin
        cnt_v_d = cnt_v_q + 10'd1;
      end
    end
  end

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_h_q <= 10'd0;
      cnt_v_q <= 10'd0;
    end else begin
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
    end
  end

  always_comb begin
    v_in_window  = (cnt_v_q >= V_ACT_BEG) && (cnt_v_q < V_ACT_END);
    rgb_valid    = v_in_window && (cnt_h_q >= H_ACT_BEG) && (cnt_h_q < H_ACT_END);
    pix_data_req = v_in_window && (cnt_h_q >= H_REQ_BEG) && (cnt_h_q < H_REQ_END);
  end

  assign hsync       = (cnt_h_q >= H_SYNC_END);
  assign vsync       = (cnt_v_q >= V_SYNC_END);
  assign frame_start = (cnt_h_q == 10'd0) && (cnt_v_q == 10'd0);

  // Subtractions cannot underflow: they are only selected inside the window.
  assign pix_x = pix_data_req ? (cnt_h_q - H_REQ_BEG) : 10'h3FF;
  assign pix_y = pix_data_req ? (cnt_v_q - V_ACT_BEG) : 10'h3FF;
  assign rgb   = rgb_valid ? pix_data : 16'h0000;

endmodule

// File: tb/tb_vga_ctrl.sv
// tb/tb_vga_ctrl.sv - self-checking bench for vga_ctrl (full-size and reduced-timing instances)
module tb_vga_ctrl;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       fs;
    logic       act;
    logic [9:0] px;
    logic [9:0] py;
    logic [9:0] ax;
    logic [9:0] ay;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b = 1'b1;
  logic        rst_s = 1'b1;
  logic        white_b = 1'b0;
  logic [15:0] pd_b = 16'h0, pd_s = 16'h0;
  logic [9:0]  pix_x_b, pix_y_b, pix_x_s, pix_y_s;
  logic        hsync_b, vsync_b, fs_b, hsync_s, vsync_s, fs_s;
  logic [15:0] rgb_b, rgb_s;

  int checks = 0;
  int errors = 0;

  longint t_b = 0, t_s = 0;
  longint first_b = -1, first_s = -1;
  int req_cnt = 0, fs_cnt = 0, vs_low = 0, hs_low = 0;

  vga_ctrl dut_b (
    .vga_clk(clk), .sys_rst(rst_b), .pix_data(pd_b),
    .pix_x(pix_x_b), .pix_y(pix_y_b), .hsync(hsync_b), .vsync(vsync_b),
    .rgb(rgb_b), .frame_start(fs_b)
  );

  // Reduced timing: H_TOTAL 19, H_ACT 8, V_TOTAL 12, V_ACT 5, frame 228 clocks.
  vga_ctrl #(
    .H_SYNC(4), .H_BACK(3), .H_LEFT(1), .H_VALID(8), .H_RIGHT(1), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(2), .V_TOP(1), .V_VALID(5), .V_BOTTOM(1), .V_FRONT(1)
  ) dut_s (
    .vga_clk(clk), .sys_rst(rst_s), .pix_data(pd_s),
    .pix_x(pix_x_s), .pix_y(pix_y_s), .hsync(hsync_s), .vsync(vsync_s),
    .rgb(rgb_s), .frame_start(fs_s)
  );

  // Clocks elapsed since reset release.
  always @(posedge clk or posedge rst_b) if (rst_b) t_b <= 0; else t_b <= t_b + 1;
  always @(posedge clk or posedge rst_s) if (rst_s) t_s <= 0; else t_s <= t_s + 1;

  // Pixel generators: registered, one clock behind the request.
  always @(posedge clk) pd_b <= white_b ? 16'hFFFF : {pix_y_b[5:0], pix_x_b};
  always @(posedge clk) pd_s <= {pix_y_s[5:0], pix_x_s};

  function automatic exp_t model(longint t, int hsw, int hact, int hval, int htot,
                                 int vsw, int vact, int vval, int vtot);
    exp_t   e;
    longint h, v, rx;
    h  = t % htot;
    v  = (t / htot) % vtot;
    e  = '0;
    e.hs = (h >= hsw);
    e.vs = (v >= vsw);
    e.fs = (h == 0) && (v == 0);
    e.px = 10'h3FF;
    e.py = 10'h3FF;
    rx = h + 1 - hact;
    if (v >= vact && v < vact + vval) begin
      if (rx >= 0 && rx < hval) begin
        e.px = 10'(rx);
        e.py = 10'(v - vact);
      end
      if (h >= hact && h < hact + hval) begin
        e.act = 1'b1;
        e.ax  = 10'(h - hact);
        e.ay  = 10'(v - vact);
      end
    end
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, got, exp);
    end
  endtask

  exp_t       eb, es;
  logic [15:0] rgb_exp;

  always begin
    @(negedge clk or posedge rst_b or posedge rst_s);
    #1;
    // ---- full-size instance ----
    eb = model(t_b, 96, 144, 640, 800, 2, 35, 480, 525);
    rgb_exp = eb.act ? (white_b ? 16'hFFFF : {eb.ay[5:0], eb.ax}) : 16'h0000;
    chk("b_hsync", 32'(hsync_b), 32'(eb.hs));
    chk("b_vsync", 32'(vsync_b), 32'(eb.vs));
    chk("b_frame_start", 32'(fs_b), 32'(eb.fs));
    chk("b_pix_x", 32'(pix_x_b), 32'(eb.px));
    chk("b_pix_y", 32'(pix_y_b), 32'(eb.py));
    chk("b_rgb", 32'(rgb_b), 32'(rgb_exp));
    if (rst_b) begin
      chk("b_rst_hsync", 32'(hsync_b), 32'd0);
      chk("b_rst_vsync", 32'(vsync_b), 32'd0);
      chk("b_rst_pix_x", 32'(pix_x_b), 32'h3FF);
      chk("b_rst_pix_y", 32'(pix_y_b), 32'h3FF);
      chk("b_rst_rgb", 32'(rgb_b), 32'h0);
      chk("b_rst_fs", 32'(fs_b), 32'd1);
    end else if (!white_b) begin
      case (t_b)
        1:     chk("b_fs_off", 32'(fs_b), 32'd0);
        95:    chk("b_hs_last_low", 32'(hsync_b), 32'd0);
        96:    chk("b_hs_rise", 32'(hsync_b), 32'd1);
        800:   chk("b_hs_next_fall", 32'(hsync_b), 32'd0);
        1599:  chk("b_vs_last_low", 32'(vsync_b), 32'd0);
        1600:  chk("b_vs_rise", 32'(vsync_b), 32'd1);
        28142: chk("b_pre_req", 32'(pix_x_b), 32'h3FF);
        28143: begin
          chk("b_first_x", 32'(pix_x_b), 32'd0);
          chk("b_first_y", 32'(pix_y_b), 32'd0);
        end
        28144: begin
          chk("b_px0_rgb", 32'(rgb_b), 32'h0000);
          chk("b_x1", 32'(pix_x_b), 32'd1);
        end
        28782: chk("b_last_req", 32'(pix_x_b), 32'd639);
        28783: begin
          chk("b_after_req", 32'(pix_x_b), 32'h3FF);
          chk("b_px639_rgb", 32'(rgb_b), 32'h027F);
        end
        28784: chk("b_post_rgb", 32'(rgb_b), 32'h0000);
        28944: begin
          chk("b_row1_rgb", 32'(rgb_b), 32'h0400);
          chk("b_row1_y", 32'(pix_y_b), 32'd1);
        end
        default: ;
      endcase
    end else begin
      case (t_b)
        28143: chk("b_w_col143", 32'(rgb_b), 32'h0000);
        28144: chk("b_w_col144", 32'(rgb_b), 32'hFFFF);
        28783: chk("b_w_col783", 32'(rgb_b), 32'hFFFF);
        28784: chk("b_w_col784", 32'(rgb_b), 32'h0000);
        default: ;
      endcase
    end
    if (t_b == 0) first_b = -1;
    else if (first_b < 0 && pix_x_b != 10'h3FF) first_b = t_b;
    if (!rst_b && t_b == 29000) chk("b_first_req_time", 32'(first_b), 32'd28143);

    // ---- reduced-timing instance ----
    es = model(t_s, 4, 8, 8, 19, 2, 5, 5, 12);
    rgb_exp = es.act ? {es.ay[5:0], es.ax} : 16'h0000;
    chk("s_hsync", 32'(hsync_s), 32'(es.hs));
    chk("s_vsync", 32'(vsync_s), 32'(es.vs));
    chk("s_frame_start", 32'(fs_s), 32'(es.fs));
    chk("s_pix_x", 32'(pix_x_s), 32'(es.px));
    chk("s_pix_y", 32'(pix_y_s), 32'(es.py));
    chk("s_rgb", 32'(rgb_s), 32'(rgb_exp));
    if (rst_s) begin
      chk("s_rst_vsync", 32'(vsync_s), 32'd0);
      chk("s_rst_pix_x", 32'(pix_x_s), 32'h3FF);
      chk("s_rst_fs", 32'(fs_s), 32'd1);
    end else begin
      case (t_s)
        37:  chk("s_vs_last_low", 32'(vsync_s), 32'd0);
        38:  chk("s_vs_rise", 32'(vsync_s), 32'd1);
        101: chk("s_pre_req", 32'(pix_x_s), 32'h3FF);
        102: chk("s_first_x", 32'(pix_x_s), 32'd0);
        default: ;
      endcase
    end
    if (t_s == 0) begin
      first_s = -1;
      req_cnt = 0; fs_cnt = 0; vs_low = 0; hs_low = 0;
    end else if (first_s < 0 && pix_x_s != 10'h3FF) begin
      first_s = t_s;
    end
    if (pix_x_s != 10'h3FF) req_cnt++;
    if (fs_s) fs_cnt++;
    if (!vsync_s) vs_low++;
    if (!hsync_s) hs_low++;
    if (!rst_s && (t_s % 228) == 227) begin
      chk("s_frame_reqs", 32'(req_cnt), 32'd40);
      chk("s_frame_fs", 32'(fs_cnt), 32'd1);
      chk("s_frame_vs_low", 32'(vs_low), 32'd38);
      chk("s_frame_hs_low", 32'(hs_low), 32'd48);
      req_cnt = 0; fs_cnt = 0; vs_low = 0; hs_low = 0;
    end
    if (!rst_s && t_s == 200) chk("s_first_req_time", 32'(first_s), 32'd102);
  end

  initial begin
    fork
      begin
        repeat (3) @(negedge clk);
        #3 rst_b = 1'b0;
        repeat (30000) @(posedge clk);   // lands at cnt_h 400, cnt_v 37
        #2 rst_b = 1'b1;
        white_b = 1'b1;
        repeat (3) @(negedge clk);
        #3 rst_b = 1'b0;
        repeat (30000) @(posedge clk);
      end
      begin
        repeat (3) @(negedge clk);
        #3 rst_s = 1'b0;
        repeat (684 + 155) @(posedge clk); // lands at cnt_h 3, cnt_v 8
        #2 rst_s = 1'b1;
        repeat (2) @(negedge clk);
        #3 rst_s = 1'b0;
        repeat (684) @(posedge clk);
      end
    join
    @(negedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
